// File: rtl/plot_pkg.sv
// plot_pkg: shared state encoding and screen/box constants for the plot engine.
package plot_pkg;

  // Controller-visible phases of the plot engine.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAW  = 2'd1,
    S_CLEAR = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int BOX      = 4;

  localparam logic [2:0] CLEAR_COLOUR = 3'd0;

endpackage : plot_pkg

// File: rtl/plot_engine_raster_counter.sv
// raster_counter: row-major x/y sweep counter. x runs 0..W-1 (inner) and wraps,
// stepping y 0..H-1 (outer). last_o flags the final (W-1,H-1) position so the
// owner can leave its sweep state on the same edge the counter wraps to (0,0).
// clr_i holds the counter at the origin while the owner is not sweeping.
module raster_counter #(
  parameter int W  = 160,
  parameter int H  = 120,
  parameter int XW = 8,
  parameter int YW = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          last_o
);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          x_wrap_s;
  logic          y_wrap_s;

  assign x_wrap_s = (x_q == XW'(W - 1));
  assign y_wrap_s = (y_q == YW'(H - 1));
  assign last_o   = x_wrap_s && y_wrap_s;
  assign x_o      = x_q;
  assign y_o      = y_q;

  // Next position: hold at origin when cleared, else advance row-major.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr_i) begin
      x_d = '0;
      y_d = '0;
    end else if (en_i) begin
      if (x_wrap_s) begin
        x_d = '0;
        if (y_wrap_s) begin
          y_d = '0;
        end else begin
          y_d = y_q + YW'(1);
        end
      end else begin
        x_d = x_q + XW'(1);
      end
    end else begin
      x_d = x_q;
    end
  end

  // Position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule : raster_counter

// File: rtl/plot_engine.sv
// plot_engine: executes load-x / plot / clear commands from the lab7 control FSM
// and drives the VGA adapter write port one pixel per cycle.
// Build option BOX_FILL_EN: when defined, plot fills a BOX x BOX square at (x,y);
// when undefined, plot writes the single pixel (x,y).
// All write-port outputs are decoded from registered state only.
module plot_engine #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int C_W      = 3,
  parameter int SCREEN_W = plot_pkg::SCREEN_W,
  parameter int SCREEN_H = plot_pkg::SCREEN_H
) (
  input  logic           clock,
  input  logic           ResetN,
  input  logic           cmd_ldx,
  input  logic           cmd_plot,
  input  logic           cmd_clear,
  input  logic [Y_W-1:0] data_in,
  input  logic [C_W-1:0] colour_in,
  output logic           busy,
  output logic           done,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic [C_W-1:0] vga_colour,
  output logic           vga_plot
);

  import plot_pkg::*;

  state_e         state_q, state_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [C_W-1:0] col_q, col_d;

  logic [X_W-1:0] clr_x_s;
  logic [Y_W-1:0] clr_y_s;
  logic           clr_last_s;
  logic           draw_last_s;
  // One bit wider than the write address so the clip test sees the carry.
  logic [X_W:0]   px_s;
  logic [Y_W:0]   py_s;

  // Full-screen sweep used by the clear command.
  raster_counter #(
    .W  (SCREEN_W),
    .H  (SCREEN_H),
    .XW (X_W),
    .YW (Y_W)
  ) u_clear_cnt (
    .clk    (clock),
    .rst_n  (ResetN),
    .clr_i  (state_q != S_CLEAR),
    .en_i   (state_q == S_CLEAR),
    .x_o    (clr_x_s),
    .y_o    (clr_y_s),
    .last_o (clr_last_s)
  );

`ifdef BOX_FILL_EN
  localparam int BW = $clog2(BOX);
  logic [BW-1:0] box_dx_s;
  logic [BW-1:0] box_dy_s;

  // Offset sweep across the box: cnt[1:0] is dx, cnt[3:2] is dy.
  raster_counter #(
    .W  (BOX),
    .H  (BOX),
    .XW (BW),
    .YW (BW)
  ) u_box_cnt (
    .clk    (clock),
    .rst_n  (ResetN),
    .clr_i  (state_q != S_DRAW),
    .en_i   (state_q == S_DRAW),
    .x_o    (box_dx_s),
    .y_o    (box_dy_s),
    .last_o (draw_last_s)
  );

  assign px_s = {1'b0, x_q} + (X_W + 1)'(box_dx_s);
  assign py_s = {1'b0, y_q} + (Y_W + 1)'(box_dy_s);
`else
  assign draw_last_s = 1'b1;
  assign px_s        = {1'b0, x_q};
  assign py_s        = {1'b0, y_q};
`endif

  // Command decode in IDLE (clear > plot > ldx) and sweep-completion transitions.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    col_d   = col_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_clear) begin
          state_d = S_CLEAR;
        end else if (cmd_plot) begin
          y_d     = data_in;
          col_d   = colour_in;
          state_d = S_DRAW;
        end else if (cmd_ldx) begin
          x_d = X_W'(data_in);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRAW: begin
        if (draw_last_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAW;
        end
      end
      S_CLEAR: begin
        if (clr_last_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_CLEAR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Write-port and handshake decode; off-screen box pixels are suppressed.
  always_comb begin
    busy       = 1'b1;
    done       = 1'b0;
    vga_plot   = 1'b0;
    vga_x      = x_q;
    vga_y      = y_q;
    vga_colour = col_q;
    case (state_q)
      S_IDLE: busy = 1'b0;
      S_DRAW: begin
        vga_x    = px_s[X_W-1:0];
        vga_y    = py_s[Y_W-1:0];
        vga_plot = (px_s < (X_W + 1)'(SCREEN_W)) && (py_s < (Y_W + 1)'(SCREEN_H));
      end
      S_CLEAR: begin
        vga_x      = clr_x_s;
        vga_y      = clr_y_s;
        vga_colour = C_W'(CLEAR_COLOUR);
        vga_plot   = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // State and latched command operands.
  always_ff @(posedge clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      col_q   <= col_d;
    end
  end

endmodule : plot_engine

// File: tb/tb_plot_engine.sv
// tb_plot_engine: directed self-checking bench for plot_engine.
// Works for either setting of BOX_FILL_EN; expected pixel lists come from the
// box/clip definition of the plot command.
module tb_plot_engine;

`ifdef BOX_FILL_EN
  localparam int NB = 4;
`else
  localparam int NB = 1;
`endif

  logic       clock     = 1'b0;
  logic       ResetN    = 1'b0;
  logic       cmd_ldx   = 1'b0;
  logic       cmd_plot  = 1'b0;
  logic       cmd_clear = 1'b0;
  logic [6:0] data_in   = 7'd0;
  logic [2:0] colour_in = 3'd0;
  logic       busy, done, vga_plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;

  always #5 clock = ~clock;

  plot_engine dut (
    .clock      (clock),
    .ResetN     (ResetN),
    .cmd_ldx    (cmd_ldx),
    .cmd_plot   (cmd_plot),
    .cmd_clear  (cmd_clear),
    .data_in    (data_in),
    .colour_in  (colour_in),
    .busy       (busy),
    .done       (done),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] wx_q[$];
  logic [6:0] wy_q[$];
  logic [2:0] wc_q[$];
  int   done_idx;
  int   busy_cnt;
  logic done_after;
  logic busy_after;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue whatever command levels are set, then log writes until done (bounded).
  // Sample i is taken just after edge N+i-1, so a box plot shows done at i=17.
  task automatic run_cmd(input int limit);
    wx_q.delete();
    wy_q.delete();
    wc_q.delete();
    done_idx = 0;
    busy_cnt = 0;
    tick();
    cmd_ldx   = 1'b0;
    cmd_plot  = 1'b0;
    cmd_clear = 1'b0;
    for (int i = 1; i <= limit; i++) begin
      if (i == 50) begin
        cmd_plot  = 1'b1;
        cmd_ldx   = 1'b1;
        data_in   = 7'd99;
        colour_in = 3'd6;
      end
      if (i == 60) begin
        cmd_plot = 1'b0;
        cmd_ldx  = 1'b0;
      end
      if (busy) busy_cnt++;
      if (vga_plot) begin
        wx_q.push_back(vga_x);
        wy_q.push_back(vga_y);
        wc_q.push_back(vga_colour);
      end
      if (done) begin
        done_idx = i;
        break;
      end
      tick();
    end
    tick();
    done_after = done;
    busy_after = busy;
  endtask

  task automatic check_plot(input string tag, input int x, input int y, input int col);
    int n;
    n = 0;
    for (int r = 0; r < NB; r++) begin
      for (int c = 0; c < NB; c++) begin
        if ((x + c) < 160 && (y + r) < 120) begin
          if (n < wx_q.size()) begin
            chk({tag, "_x"}, wx_q[n], x + c);
            chk({tag, "_y"}, wy_q[n], y + r);
            chk({tag, "_col"}, wc_q[n], col);
          end
          n++;
        end
      end
    end
    chk({tag, "_writes"}, wx_q.size(), n);
    chk({tag, "_done_idx"}, done_idx, NB * NB + 1);
    chk({tag, "_busy_cycles"}, busy_cnt, NB * NB + 1);
    chk({tag, "_done_width"}, done_after, 1'b0);
    chk({tag, "_idle_busy"}, busy_after, 1'b0);
  endtask

  task automatic ldx(input logic [6:0] v);
    cmd_ldx = 1'b1;
    data_in = v;
    tick();
    cmd_ldx = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_plot"}, vga_plot, 1'b0);
    chk({tag, "_x"}, vga_x, 8'd0);
    chk({tag, "_y"}, vga_y, 7'd0);
    chk({tag, "_col"}, vga_colour, 3'd0);
  endtask

  initial begin
    int nz;
    int dones;
    int busys;

    // Reset state.
    repeat (3) tick();
    check_reset_outputs("reset");
    ResetN = 1'b1;
    tick();

    // Load x only: no write, no handshake activity.
    ldx(7'd10);
    chk("ldx_x", vga_x, 8'd10);
    chk("ldx_y", vga_y, 7'd0);
    chk("ldx_busy", busy, 1'b0);
    chk("ldx_plot", vga_plot, 1'b0);

    // Plot at (10,20) colour 4.
    data_in   = 7'd20;
    colour_in = 3'b100;
    cmd_plot  = 1'b1;
    run_cmd(40);
    check_plot("plot1", 10, 20, 4);
    chk("plot1_first_x", wx_q.size() > 0 ? wx_q[0] : 8'hff, 8'd10);
    chk("idle_x", vga_x, 8'd10);
    chk("idle_y", vga_y, 7'd20);
    chk("idle_col", vga_colour, 3'd4);

    // Near bottom edge: rows 120+ clipped.
    ldx(7'd126);
    data_in   = 7'd118;
    colour_in = 3'd2;
    cmd_plot  = 1'b1;
    run_cmd(40);
    check_plot("clip", 126, 118, 2);
    chk("clip_count", wx_q.size(), (NB == 4) ? 8 : 1);

    // Single-pixel reference point (5,9).
    ldx(7'd5);
    data_in   = 7'd9;
    colour_in = 3'd7;
    cmd_plot  = 1'b1;
    run_cmd(40);
    check_plot("p5_9", 5, 9, 7);

    // Entirely off-screen: no writes, handshake unchanged.
    data_in   = 7'd127;
    colour_in = 3'd1;
    cmd_plot  = 1'b1;
    run_cmd(40);
    check_plot("allclip", 5, 127, 1);

    // Clear + plot + ldx on the same edge: clear wins; pokes during busy ignored.
    data_in   = 7'd33;
    colour_in = 3'd5;
    cmd_clear = 1'b1;
    cmd_plot  = 1'b1;
    cmd_ldx   = 1'b1;
    run_cmd(20000);
    nz = 0;
    foreach (wc_q[i]) if (wc_q[i] !== 3'd0) nz++;
    chk("clear_writes", wx_q.size(), 19200);
    chk("clear_nonzero_col", nz, 0);
    chk("clear_first_x", wx_q.size() > 0 ? wx_q[0] : 8'hff, 8'd0);
    chk("clear_first_y", wy_q.size() > 0 ? wy_q[0] : 7'h7f, 7'd0);
    chk("clear_row1_x", wx_q.size() > 160 ? wx_q[160] : 8'hff, 8'd0);
    chk("clear_row1_y", wy_q.size() > 160 ? wy_q[160] : 7'h7f, 7'd1);
    chk("clear_last_x", wx_q.size() > 0 ? wx_q[wx_q.size() - 1] : 8'hff, 8'd159);
    chk("clear_last_y", wy_q.size() > 0 ? wy_q[wy_q.size() - 1] : 7'h7f, 7'd119);
    chk("clear_done_idx", done_idx, 19201);
    chk("clear_busy_cycles", busy_cnt, 19201);
    chk("clear_done_width", done_after, 1'b0);
    chk("clear_keeps_x", vga_x, 8'd5);
    chk("clear_keeps_y", vga_y, 7'd127);
    chk("clear_keeps_col", vga_colour, 3'd1);

    // Reset in the middle of a sweep aborts with no done pulse.
    data_in   = 7'd20;
    colour_in = 3'd3;
`ifdef BOX_FILL_EN
    cmd_plot = 1'b1;
`else
    cmd_clear = 1'b1;
`endif
    tick();
    cmd_plot  = 1'b0;
    cmd_clear = 1'b0;
    repeat (5) tick();
    chk("mid_plot", vga_plot, 1'b1);
`ifdef BOX_FILL_EN
    chk("mid_x", vga_x, 8'd6);
    chk("mid_y", vga_y, 7'd21);
`else
    chk("mid_x", vga_x, 8'd5);
    chk("mid_y", vga_y, 7'd0);
`endif
    #1;
    ResetN = 1'b0;
    #1;
    check_reset_outputs("abort");
    tick();
    tick();
    ResetN = 1'b1;
    dones = 0;
    busys = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done) dones++;
      if (busy) busys++;
    end
    chk("abort_no_done", dones, 0);
    chk("abort_idle", busys, 0);
    chk("abort_x_cleared", vga_x, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_plot_engine
